elevator_ctrl_n: RTL and testbench

Parametrised successor to the 3-floor elevator controller. Serves NFLOORS floors with latched cabin (FB) and hall (CALL) requests and collective up/down (SCAN) scheduling. Generates an animated door pattern, a seven-segment floor indicator and a direction flag. It sits between the debounced active-low pushbuttons and the board LEDs and 7-seg display.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/elevator_req_latch.sv | 16 +
 rtl/elevator_ctrl_n.sv | 127 ++++++++++++
 tb/tb_elevator_ctrl_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, door patterns and seven-segment table for the elevator controller
package elevator_pkg;
  typedef enum logic [2:0] {IDLE, OPENING, DWELL, CLOSING, MOVE_UP, MOVE_DN} state_t;
  localparam int FW = 3;
  localparam logic [5:0] DOOR_CLOSE = 6'b111111;
  localparam logic [5:0] DOOR_OPEN1 = 6'b110011;
  localparam logic [5:0] DOOR_OPEN2 = 6'b100001;
  localparam logic [5:0] DOOR_OPEN3 = 6'b000000;
  localparam logic [6:0] SEG [8] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                     7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111};
  function automatic logic [5:0] door_pat(input logic [1:0] s);
    return s == 2'd0 ? DOOR_CLOSE : s == 2'd1 ? DOOR_OPEN1 : s == 2'd2 ? DOOR_OPEN2 : DOOR_OPEN3;
  endfunction
endpackage

// File: rtl/elevator_req_latch.sv
// elevator_req_latch: per-floor request flags, set by masked presses, cleared when the door starts opening there
module elevator_req_latch #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] set,
  input  logic [N-1:0] ign,
  input  logic [N-1:0] clr,
  output logic [N-1:0] req
);
  // clear dominates a same-clock set
  always_ff @(posedge clk or negedge reset)
    if (!reset) req <= '0;
    else req <= (req | (set & ~ign)) & ~clr;
endmodule

// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor SCAN elevator controller; ELEV_REOPEN_EN lets a press at the floor reopen a closing door
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int NFLOORS    = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int STEP_CYC   = 1,
  parameter int DWELL_CYC  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] FB,
  input  logic [NFLOORS-1:0] CALL,
  output logic [5:0]         DOOR,
  output logic [6:0]         FI,
  output logic               UD,
  output logic [FW-1:0]      FLOOR,
  output logic               BUSY
);
  state_t state, state_n;
  logic [FW-1:0] floor_n, nf;
  logic ud_n;
  logic [1:0] step, step_n;
  logic [15:0] cnt, cnt_n;
  logic [NFLOORS-1:0] req, btn, clr, ign, eq, gt, lt, eq_n, gt_n, lt_n;
  logic here, above, below, here_n, above_n, below_n;
  assign btn = ~FB | ~CALL;
  assign ign = state == IDLE ? '0 : eq;
  elevator_req_latch #(.N(NFLOORS)) u_req (
    .clk(clk), .reset(reset), .set(btn), .ign(ign), .clr(clr), .req(req)
  );
  // floor masks relative to the current floor and to the floor being approached
  always_comb begin
    nf = state == MOVE_DN ? FLOOR - 3'd1 : FLOOR + 3'd1;
    for (int i = 0; i < NFLOORS; i++) begin
      eq[i]   = i == int'(FLOOR);
      gt[i]   = i > int'(FLOOR);
      lt[i]   = i < int'(FLOOR);
      eq_n[i] = i == int'(nf);
      gt_n[i] = i > int'(nf);
      lt_n[i] = i < int'(nf);
    end
    here    = |(req & eq);
    above   = |(req & gt);
    below   = |(req & lt);
    here_n  = |(req & eq_n);
    above_n = |(req & gt_n);
    below_n = |(req & lt_n);
  end
  // next-state, door step, travel/dwell counter and request clear
  always_comb begin
    state_n = state;
    floor_n = FLOOR;
    ud_n    = UD;
    step_n  = step;
    cnt_n   = cnt + 16'd1;
    clr     = '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (here) begin
          state_n = OPENING;
          clr     = eq;
        end else if (above && (UD || !below)) begin
          state_n = MOVE_UP;
          ud_n    = 1'b1;
        end else if (below) begin
          state_n = MOVE_DN;
          ud_n    = 1'b0;
        end
      end
      OPENING:
        if (cnt == 16'(STEP_CYC - 1)) begin
          cnt_n   = '0;
          step_n  = step + 2'd1;
          state_n = step == 2'd2 ? DWELL : OPENING;
        end
      DWELL:
        if (cnt == 16'(DWELL_CYC - 1)) begin
          cnt_n   = '0;
          step_n  = 2'd2;
          state_n = CLOSING;
        end
      CLOSING:
`ifdef ELEV_REOPEN_EN
        if (|(btn & eq)) begin
          cnt_n   = '0;
          state_n = OPENING;
          clr     = eq;
        end else
`endif
        if (cnt == 16'(STEP_CYC - 1)) begin
          cnt_n   = '0;
          step_n  = step - 2'd1;
          state_n = step == 2'd1 ? IDLE : CLOSING;
        end
      MOVE_UP, MOVE_DN:
        if (cnt == 16'(TRAVEL_CYC - 1)) begin
          cnt_n   = '0;
          floor_n = nf;
          if (here_n) begin
            state_n = OPENING;
            clr     = eq_n;
          end else if (!(state == MOVE_UP ? above_n : below_n)) state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  // controller state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      FLOOR <= '0;
      UD    <= 1'b1;
      step  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      FLOOR <= floor_n;
      UD    <= ud_n;
      step  <= step_n;
      cnt   <= cnt_n;
    end
  assign DOOR = door_pat(step);
  assign FI   = SEG[FLOOR];
  assign BUSY = state != IDLE;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: table-driven and directed checks of the elevator controller at 3 and 8 floors
module tb_elevator_ctrl_n;
  localparam logic [5:0] D0 = 6'b111111, D1 = 6'b110011, D2 = 6'b100001, D3 = 6'b000000;
  localparam logic [6:0] S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001, S8 = 7'b1111111;
  localparam logic [2:0] N = 3'b111;
  typedef struct {
    logic [2:0] fb, call;
    logic [5:0] door;
    logic [6:0] fi;
    logic       ud;
    logic [2:0] fl;
    logic       busy;
  } vec_t;
  vec_t tv[$];
  int n_vec = 0, n_err = 0;
  logic clk = 0, reset = 0;
  logic [2:0] fb3 = '1, call3 = '1;
  logic [7:0] fb8 = '1, call8 = '1;
  logic [5:0] door3, door8;
  logic [6:0] fi3, fi8;
  logic ud3, ud8, busy3, busy8;
  logic [2:0] fl3, fl8;
  always #5 clk = ~clk;
  elevator_ctrl_n #(.NFLOORS(3)) u3 (
    .clk(clk), .reset(reset), .FB(fb3), .CALL(call3),
    .DOOR(door3), .FI(fi3), .UD(ud3), .FLOOR(fl3), .BUSY(busy3)
  );
  elevator_ctrl_n #(.NFLOORS(8)) u8 (
    .clk(clk), .reset(reset), .FB(fb8), .CALL(call8),
    .DOOR(door8), .FI(fi8), .UD(ud8), .FLOOR(fl8), .BUSY(busy8)
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic [2:0] fb, input logic [2:0] call);
    @(negedge clk);
    fb3 = fb; call3 = call; fb8 = '1; call8 = '1;
    @(posedge clk);
    #1;
  endtask
  task automatic cyc8(input logic [7:0] fb, input logic [7:0] call);
    @(negedge clk);
    fb8 = fb; call8 = call; fb3 = '1; call3 = '1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(N, N);
  endtask
  task automatic add(input logic [2:0] fb, input logic [2:0] call, input logic [5:0] door,
                     input logic [6:0] fi, input logic ud, input logic [2:0] fl, input logic busy);
    tv.push_back('{fb, call, door, fi, ud, fl, busy});
  endtask
  initial begin
    add(N, N, D0, S1, 1, 0, 0);
    add(N, 3'b110, D0, S1, 1, 0, 0);
    add(N, N, D0, S1, 1, 0, 1);
    add(N, N, D1, S1, 1, 0, 1);
    add(N, N, D2, S1, 1, 0, 1);
    repeat (4) add(N, N, D3, S1, 1, 0, 1);
    add(N, N, D2, S1, 1, 0, 1);
    add(N, N, D1, S1, 1, 0, 1);
    add(N, N, D0, S1, 1, 0, 0);
    add(3'b011, N, D0, S1, 1, 0, 0);
    repeat (4) add(N, N, D0, S1, 1, 0, 1);
    repeat (4) add(N, N, D0, S2, 1, 1, 1);
    add(N, N, D0, S3, 1, 2, 1);
    add(N, N, D1, S3, 1, 2, 1);
    add(N, N, D2, S3, 1, 2, 1);
    repeat (4) add(N, N, D3, S3, 1, 2, 1);
    add(N, N, D2, S3, 1, 2, 1);
    add(N, N, D1, S3, 1, 2, 1);
    add(N, N, D0, S3, 1, 2, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst door", 8'(door3), 8'(D0));
    chk("rst fi", 8'(fi3), 8'(S1));
    chk("rst ud", 8'(ud3), 8'd1);
    chk("rst floor", 8'(fl3), 8'd0);
    chk("rst busy", 8'(busy3), 8'd0);
    @(negedge clk);
    reset = 1;
    foreach (tv[i]) begin
      cyc(tv[i].fb, tv[i].call);
      chk($sformatf("vec%0d door", i), 8'(door3), 8'(tv[i].door));
      chk($sformatf("vec%0d fi", i), 8'(fi3), 8'(tv[i].fi));
      chk($sformatf("vec%0d ud", i), 8'(ud3), 8'(tv[i].ud));
      chk($sformatf("vec%0d floor", i), 8'(fl3), 8'(tv[i].fl));
      chk($sformatf("vec%0d busy", i), 8'(busy3), 8'(tv[i].busy));
    end
    cyc(3'b110, N);
    idle(1);
    chk("dn start ud", 8'(ud3), 8'd0);
    chk("dn start busy", 8'(busy3), 8'd1);
    idle(8);
    chk("dn arrive floor", 8'(fl3), 8'd0);
    idle(9);
    chk("dn done busy", 8'(busy3), 8'd0);
    cyc(3'b011, N);
    idle(1);
    chk("scan up ud", 8'(ud3), 8'd1);
    idle(4);
    chk("scan at 1", 8'(fl3), 8'd1);
    cyc(N, 3'b110);
    idle(3);
    chk("scan serve 2 floor", 8'(fl3), 8'd2);
    chk("scan serve 2 ud", 8'(ud3), 8'd1);
    chk("scan serve 2 door", 8'(door3), 8'(D0));
    chk("scan serve 2 busy", 8'(busy3), 8'd1);
    idle(9);
    chk("scan idle at 2", 8'(busy3), 8'd0);
    idle(1);
    chk("scan reverse ud", 8'(ud3), 8'd0);
    chk("scan reverse busy", 8'(busy3), 8'd1);
    idle(8);
    chk("scan back floor", 8'(fl3), 8'd0);
    chk("scan back fi", 8'(fi3), 8'(S1));
    idle(8);
    chk("closing door", 8'(door3), 8'(D1));
    cyc(3'b110, N);
`ifdef ELEV_REOPEN_EN
    chk("reopen hold", 8'(door3), 8'(D1));
    chk("reopen busy", 8'(busy3), 8'd1);
    idle(1);
    chk("reopen step", 8'(door3), 8'(D2));
    idle(1);
    chk("reopen open", 8'(door3), 8'(D3));
    idle(3);
    chk("reopen dwell end", 8'(door3), 8'(D3));
    idle(1);
    chk("reopen close", 8'(door3), 8'(D2));
    idle(6);
`else
    chk("no reopen door", 8'(door3), 8'(D0));
    chk("no reopen busy", 8'(busy3), 8'd0);
    idle(1);
    chk("no reopen stays", 8'(busy3), 8'd0);
    chk("no reopen door2", 8'(door3), 8'(D0));
    idle(4);
`endif
    cyc8(8'h7F, 8'hFF);
    idle(1);
    chk("n8 start busy", 8'(busy8), 8'd1);
    chk("n8 start ud", 8'(ud8), 8'd1);
    idle(28);
    chk("n8 top floor", 8'(fl8), 8'd7);
    chk("n8 top fi", 8'(fi8), 8'(S8));
    idle(19);
    chk("n8 stay floor", 8'(fl8), 8'd7);
    chk("n8 stay busy", 8'(busy8), 8'd0);
    cyc8(8'h7F, 8'hFF);
    idle(1);
    chk("n8 reopen busy", 8'(busy8), 8'd1);
    idle(1);
    chk("n8 reopen door", 8'(door8), 8'(D1));
    chk("n8 reopen floor", 8'(fl8), 8'd7);
    cyc(3'b011, N);
    idle(5);
    chk("pre rst floor", 8'(fl3), 8'd1);
    chk("pre rst busy", 8'(busy3), 8'd1);
    #2 reset = 0;
    #1;
    chk("async rst floor", 8'(fl3), 8'd0);
    chk("async rst fi", 8'(fi3), 8'(S1));
    chk("async rst door", 8'(door3), 8'(D0));
    chk("async rst ud", 8'(ud3), 8'd1);
    chk("async rst busy", 8'(busy3), 8'd0);
    chk("async rst n8 floor", 8'(fl8), 8'd0);
    @(negedge clk);
    reset = 1;
    idle(3);
    chk("post rst busy", 8'(busy3), 8'd0);
    chk("post rst floor", 8'(fl3), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
